// File: rtl/lc3_control_fsm.sv
// LC-3 multi-cycle control unit. A single state register sequences fetch, decode and
// execute; all datapath controls are decoded combinationally from the current state.
// Memory states hold for MEM_WAIT+1 cycles using a small wait counter.
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT    = 3,
  parameter int unsigned DEBUG_PAUSE = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,

  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,

  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,

  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,

  output logic       Mem_OE,
  output logic       Mem_WE
);

  // Mux select encodings.
  localparam logic [1:0] PcmuxInc    = 2'b00;
  localparam logic [1:0] PcmuxAdder  = 2'b10;
  localparam logic [1:0] Addr2Off6   = 2'b01;
  localparam logic [1:0] Addr2Off9   = 2'b10;
  localparam logic [1:0] Addr2Off11  = 2'b11;
  localparam logic [1:0] AlukAdd     = 2'b00;
  localparam logic [1:0] AlukAnd     = 2'b01;
  localparam logic [1:0] AlukNot     = 2'b10;
  localparam logic [1:0] AlukPassA   = 2'b11;

  // Opcodes decoded in S32.
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpJsr = 4'b0100;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpPse = 4'b1101;

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

  typedef enum logic [4:0] {
    Halted,
    S18,
    S33,
    S35,
    S32,
    S01,
    S05,
    S09,
    S00,
    S22,
    S12,
    S04,
    S20,
    S21,
    S06,
    S25,
    S27,
    S07,
    S23,
    S16,
    PauseIR1,
    PauseIR2
  } state_e;

  state_e     state_q;
  logic [3:0] wait_q;
  logic       mem_done;

  // The current memory access has been held for its full MEM_WAIT+1 cycles.
  assign mem_done = (wait_q == WaitLast);

  // State sequencing and memory wait counting; the counter is zero outside memory states.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= Halted;
      wait_q  <= 4'd0;
    end else begin
      wait_q <= 4'd0;
      case (state_q)
        Halted: begin
          if (Run) state_q <= S18;
        end
        S18: state_q <= S33;
        S33: begin
          if (mem_done) state_q <= S35;
          else          wait_q  <= wait_q + 4'd1;
        end
        S35: begin
          if (DEBUG_PAUSE != 0) state_q <= PauseIR1;
          else                  state_q <= S32;
        end
        S32: begin
          case (Opcode)
            OpAdd:   state_q <= S01;
            OpAnd:   state_q <= S05;
            OpNot:   state_q <= S09;
            OpBr:    state_q <= S00;
            OpJmp:   state_q <= S12;
            OpJsr:   state_q <= S04;
            OpLdr:   state_q <= S06;
            OpStr:   state_q <= S07;
            OpPse:   state_q <= PauseIR1;
            default: state_q <= S18;  // unsupported opcodes act as NOP
          endcase
        end
        S01, S05, S09: state_q <= S18;
        S00: begin
          if (BEN) state_q <= S22;
          else     state_q <= S18;
        end
        S22: state_q <= S18;
        S12: state_q <= S18;
        // R7 is written here, so a JSRR through R7 reads the new link value in S20.
        S04: begin
          if (IR_11) state_q <= S21;
          else       state_q <= S20;
        end
        S20: state_q <= S18;
        S21: state_q <= S18;
        S06: state_q <= S25;
        S25: begin
          if (mem_done) state_q <= S27;
          else          wait_q  <= wait_q + 4'd1;
        end
        S27: state_q <= S18;
        S07: state_q <= S23;
        S23: state_q <= S16;
        S16: begin
          if (mem_done) state_q <= S18;
          else          wait_q  <= wait_q + 4'd1;
        end
        PauseIR1: begin
          if (Continue) state_q <= PauseIR2;
        end
        PauseIR2: begin
          if (!Continue) state_q <= S18;
        end
        default: state_q <= S18;
      endcase
    end
  end

  // Datapath controls decoded from the current state; everything defaults low.
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PcmuxInc;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = AlukAdd;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    case (state_q)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PcmuxInc;
      end
      S33, S25: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      S16: Mem_WE = 1'b1;
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = (state_q == S01) ? AlukAdd : AlukAnd;
      end
      S09: begin
        SR1MUX  = 1'b1;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = AlukNot;
      end
      S22: begin
        ADDR2MUX = Addr2Off9;
        PCMUX    = PcmuxAdder;
        LD_PC    = 1'b1;
      end
      S12, S20: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = PcmuxAdder;
        LD_PC    = 1'b1;
      end
      S04: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S21: begin
        ADDR2MUX = Addr2Off11;
        PCMUX    = PcmuxAdder;
        LD_PC    = 1'b1;
      end
      S06, S07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = Addr2Off6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      // Store data comes from SR (IR[11:9]) through the ALU onto the bus into MDR.
      S23: begin
        ALUK    = AlukPassA;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      PauseIR1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: a stimulus process walks randomized instructions
// and pushes the expected per-cycle control word; a monitor pops and compares each cycle.
module tb_lc3_control_fsm;

  localparam int unsigned MemWait = 3;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

  lc3_control_fsm #(.MEM_WAIT(MemWait), .DEBUG_PAUSE(0)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we;
  } ctrl_t;

  ctrl_t act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE};

  always #5 Clk = ~Clk;

  ctrl_t sb[$];
  ctrl_t mon_exp;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    halted = 1'b0;

  // Monitor: one expected control word per cycle, sampled mid-cycle.
  always @(negedge Clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      checks++;
      if (act !== mon_exp) begin
        errors++;
        $display("FAIL ctrl cycle %0d got %h want %h", cyc, act, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Advance one clock edge and record what the outputs must look like afterwards.
  task automatic step(input ctrl_t e);
    @(posedge Clk);
    #1;
    sb.push_back(e);
  endtask

  // Run and Continue are don't-cares outside Halted and the pause states.
  task automatic noise();
    Run      = 1'($urandom);
    Continue = 1'($urandom);
  endtask

  task automatic do_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                          input logic ben, input bit pre_cont, input bit rst_str);
    ctrl_t c, rd, we, jmp, led;
    int    n;
    rd = '0;  rd.mem_oe = 1; rd.ld_mdr = 1;
    we = '0;  we.mem_we = 1;
    jmp = '0; jmp.sr1mux = 1; jmp.addr1mux = 1; jmp.pcmux = 2'b10; jmp.ld_pc = 1;
    led = '0; led.ld_led = 1;
    // Fetch: PC to MAR, memory read, MDR to IR, decode.
    c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pcmux = 2'b00;
    step(c); noise();
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    repeat (MemWait + 1) begin step(rd); noise(); end
    c = '0; c.gate_mdr = 1; c.ld_ir = 1; step(c); noise();
    c = '0; c.ld_ben = 1; step(c); noise();
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = '0; c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.aluk   = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        c.sr2mux = (op == 4'b1001) ? 1'b0 : ir5;
        step(c); noise();
      end
      4'b0000: begin
        step('0); noise();
        if (ben) begin
          c = '0; c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1;
          step(c); noise();
        end
      end
      4'b1100: begin step(jmp); noise(); end
      4'b0100: begin
        c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; step(c); noise();
        if (ir11) begin
          c = '0; c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1; step(c);
        end else begin
          step(jmp);
        end
        noise();
      end
      4'b0110, 4'b0111: begin
        c = '0; c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1;
        c.ld_mar = 1;
        step(c); noise();
        if (op == 4'b0110) begin
          repeat (MemWait + 1) begin step(rd); noise(); end
          c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; step(c); noise();
        end else begin
          c = '0; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; step(c); noise();
          if (rst_str) begin
            step(we); noise();
            step(we);
            // Reset wins over Run and Continue mid-write.
            Reset = 1; Run = 1; Continue = 1;
            step('0);
            Reset = 0; Run = 0; Continue = 1'($urandom);
            step('0);
            halted = 1'b1;
          end else begin
            repeat (MemWait + 1) begin step(we); noise(); end
          end
        end
      end
      4'b1101: begin
        Continue = pre_cont;
        step(led);
        if (!pre_cont) begin
          Continue = 0;
          n = int'($urandom_range(0, 3));
          repeat (n) begin Run = 1'($urandom); step(led); end
          Continue = 1;
        end
        step('0);
        n = int'($urandom_range(0, 2));
        repeat (n) begin Run = 1'($urandom); step('0); end
        Continue = 0;
      end
      default: ;
    endcase
  endtask

  logic [3:0] dir_ops[15] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'h0, 4'hC, 4'h4, 4'h4, 4'h6,
                              4'h7, 4'h7, 4'hD, 4'hD, 4'h3, 4'hF};

  initial begin
    Reset = 1; Run = 0; Continue = 0; Opcode = '0; IR_5 = 0; IR_11 = 0; BEN = 0;
    step('0);
    step('0);
    Reset = 0; Continue = 1;
    step('0);
    step('0);
    Run = 1;
    for (int i = 0; i < 15; i++) begin
      if (halted) begin Run = 1; halted = 1'b0; end
      do_instr(dir_ops[i], 1'(i), 1'(i), 1'(i), (i == 12), (i == 10));
    end
    for (int i = 0; i < 160; i++) begin
      if (halted) begin Run = 1; halted = 1'b0; end
      do_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 5) == 0));
    end
    @(negedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain leftover %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
